// File: rtl/image_streamer.sv
// Image streamer: buffers host pixel words in a FIFO and feeds them to the network
// in FRAME_WORDS-long frames, gated by a weight-load handshake.
module image_streamer #(
  parameter int FRAME_WORDS = 784,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_load,
  input  logic        load_weight_done,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        load,
  output logic        input_valid,
  output logic        sof,
  output logic [31:0] d_in,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);
  // state | meaning
  // IDLE  | waiting for start_load; host words are buffered, nothing emitted
  // LOAD  | load=1 until the network reports load_weight_done
  // RUN   | FIFO drains one word per cycle to the network
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_WORDS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [IW-1:0] word_idx;
  logic          push;
  logic          pop;

  assign s_ready = (count < FULL_CNT);
  assign push    = s_valid && s_ready;
  assign pop     = (state == RUN) && (count != '0);

  // Reload only between frames and only when nothing is being emitted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      load  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_load) begin
          state <= LOAD;
          load  <= 1'b1;
        end
        LOAD: if (load_weight_done) begin
          state <= RUN;
          load  <= 1'b0;
        end
        RUN: if (start_load && (word_idx == '0) && !pop) begin
          state <= LOAD;
          load  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          load  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // d_in holds its last value across gaps; sof/frame_done only with a valid word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      input_valid <= 1'b0;
      sof         <= 1'b0;
      frame_done  <= 1'b0;
      d_in        <= '0;
      frame_cnt   <= '0;
      word_idx    <= '0;
    end else begin
      input_valid <= pop;
      sof         <= pop && (word_idx == '0);
      frame_done  <= pop && (word_idx == LAST_IDX);
      if (pop) begin
        d_in <= mem[rd_ptr];
        if (word_idx == LAST_IDX) begin
          word_idx  <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          word_idx <= word_idx + IDX_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_image_streamer.sv
// Bench for image_streamer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_image_streamer;
  localparam int FW    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_load = 1'b0;
  logic        load_weight_done = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic        load;
  logic        input_valid;
  logic        sof;
  logic [31:0] d_in;
  logic        frame_done;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  image_streamer #(.FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start_load(start_load), .load_weight_done(load_weight_done),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .load(load),
    .input_valid(input_valid), .sof(sof), .d_in(d_in), .frame_done(frame_done),
    .frame_cnt(frame_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word queue plus frame position, advanced once per rising edge.
  typedef enum {M_IDLE, M_LOAD, M_RUN} mstate_t;
  mstate_t     m_state = M_IDLE;
  logic [31:0] m_q[$];
  int          m_idx = 0;
  int          m_frames = 0;
  logic        e_valid = 1'b0;
  logic        e_sof = 1'b0;
  logic        e_fd = 1'b0;
  logic        e_load = 1'b0;
  logic [31:0] e_d = '0;

  always @(posedge clk or negedge rst) begin
    bit popped;
    bit pushed;
    int idx0;
    if (!rst) begin
      m_state = M_IDLE;
      m_q.delete();
      m_idx = 0;
      m_frames = 0;
      e_valid = 0; e_sof = 0; e_fd = 0; e_load = 0; e_d = '0;
    end else begin
      idx0   = m_idx;
      pushed = s_valid && (m_q.size() < DEPTH);
      popped = (m_state == M_RUN) && (m_q.size() > 0);
      e_valid = popped;
      e_sof = 0;
      e_fd  = 0;
      if (popped) begin
        e_d   = m_q.pop_front();
        e_sof = (m_idx == 0);
        e_fd  = (m_idx == FW - 1);
        m_idx = (m_idx + 1) % FW;
        if (e_fd) m_frames = (m_frames + 1) % 65536;
      end
      if (pushed) m_q.push_back(s_data);
      case (m_state)
        M_IDLE: if (start_load) m_state = M_LOAD;
        M_LOAD: if (load_weight_done) m_state = M_RUN;
        M_RUN:  if (start_load && idx0 == 0 && !popped) m_state = M_LOAD;
        default: m_state = M_IDLE;
      endcase
      e_load = (m_state == M_LOAD);
    end
  end

  // Observation log for the literal scenario checks.
  logic [31:0] obs_d[$];
  bit          obs_sof[$];
  bit          obs_fd[$];
  int          obs_cyc[$];
  int          cyc = 0;
  int          load_hi = 0;
  int          n_acc = 0;
  int          ready_low_at = -1;

  always @(negedge clk) begin
    cyc++;
    chk("s_ready", 32'(s_ready), 32'(m_q.size() < DEPTH));
    chk("load", 32'(load), 32'(e_load));
    chk("input_valid", 32'(input_valid), 32'(e_valid));
    chk("sof", 32'(sof), 32'(e_sof));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("d_in", d_in, e_d);
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    if (input_valid) begin
      obs_d.push_back(d_in);
      obs_sof.push_back(sof);
      obs_fd.push_back(frame_done);
      obs_cyc.push_back(cyc);
    end
    if (load) load_hi++;
    if (!s_ready && ready_low_at < 0) ready_low_at = n_acc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    int  t;
    bit  acc;
    t = 0;
    acc = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = s_ready;
      step();
      t++;
    end
    s_valid = 1'b0;
    if (acc) n_acc++;
    else begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: word %0h not accepted within 200 cycles", w);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
  endtask

  task automatic clear_obs();
    obs_d.delete();
    obs_sof.delete();
    obs_fd.delete();
    obs_cyc.delete();
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    step();
    start_load = 1'b0;
  endtask

  task automatic pulse_done();
    load_weight_done = 1'b1;
    step();
    load_weight_done = 1'b0;
  endtask

  initial begin
    int mark;
    // Load sequence: done raised 5 cycles after the start pulse ends
    do_reset();
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    load_hi = 0;
    pulse_start();
    repeat (5) step();
    pulse_done();
    repeat (2) step();
    chk("load_high_cycles", load_hi, 32'd6);

    // One full frame back-to-back
    clear_obs();
    for (int i = 0; i < 4; i++) push_word(32'h11 + i);
    repeat (6) step();
    chk("t2_count", obs_d.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_data", obs_d[i], 32'h11 + i);
      chk("t2_sof", 32'(obs_sof[i]), (i == 0) ? 32'd1 : 32'd0);
      chk("t2_fd", 32'(obs_fd[i]), (i == 3) ? 32'd1 : 32'd0);
      chk("t2_consecutive", obs_cyc[i], obs_cyc[0] + i);
    end
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd1);

    // 20 words pushed while IDLE, then a load sequence
    do_reset();
    clear_obs();
    n_acc = 0;
    ready_low_at = -1;
    fork
      for (int i = 1; i <= 20; i++) push_word(32'h100 + i);
      begin
        repeat (25) step();
        pulse_start();
        step();
        pulse_done();
      end
    join
    repeat (30) step();
    chk("t3_ready_low_after", ready_low_at, 32'd16);
    chk("t3_count", obs_d.size(), 32'd20);
    for (int i = 0; i < 20; i++) chk("t3_order", obs_d[i], 32'h101 + i);
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd5);

    // Host stall of 3 cycles mid-frame
    clear_obs();
    push_word(32'h21);
    push_word(32'h22);
    repeat (3) step();
    push_word(32'h23);
    push_word(32'h24);
    repeat (6) step();
    chk("t4_count", obs_d.size(), 32'd4);
    chk("t4_gap", obs_cyc[2] - obs_cyc[1] - 1, 32'd3);
    chk("t4_sof_pattern", {obs_sof[0], obs_sof[1], obs_sof[2], obs_sof[3]}, 32'b1000);
    chk("t4_fd_pattern", {obs_fd[0], obs_fd[1], obs_fd[2], obs_fd[3]}, 32'b0001);
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd6);

    // start_load mid-frame ignored, at frame boundary honoured
    load_hi = 0;
    push_word(32'h31);
    push_word(32'h32);
    repeat (4) step();
    pulse_start();
    step();
    chk("t5_midframe_no_load", load_hi, 32'd0);
    push_word(32'h33);
    push_word(32'h34);
    repeat (4) step();
    mark = obs_d.size();
    pulse_start();
    for (int i = 0; i < 4; i++) push_word(32'h41 + i);
    repeat (3) step();
    chk("t5_paused", obs_d.size(), mark);
    chk("t5_load_seen", 32'(load_hi > 0), 32'd1);
    pulse_done();
    repeat (8) step();
    chk("t5_count", obs_d.size(), mark + 4);
    chk("t5_first", obs_d[mark], 32'h41);
    chk("t5_first_sof", 32'(obs_sof[mark]), 32'd1);
    chk("t5_last_fd", 32'(obs_fd[mark+3]), 32'd1);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd8);

    // Asynchronous reset while word 2 is on the output
    push_word(32'h51);
    push_word(32'h52);
    push_word(32'h53);
    chk("t6_word2_out", d_in, 32'h52);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(input_valid), 32'd0);
    chk("t6_rst_d_in", d_in, 32'd0);
    chk("t6_rst_sof", 32'(sof), 32'd0);
    chk("t6_rst_fd", 32'(frame_done), 32'd0);
    chk("t6_rst_load", 32'(load), 32'd0);
    chk("t6_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    repeat (2) step();
    rst = 1'b1;
    step();
    pulse_start();
    step();
    pulse_done();
    clear_obs();
    for (int i = 0; i < 4; i++) push_word(32'h61 + i);
    repeat (6) step();
    chk("t6_count", obs_d.size(), 32'd4);
    chk("t6_first", obs_d[0], 32'h61);
    chk("t6_first_sof", 32'(obs_sof[0]), 32'd1);
    chk("t6_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

endmodule

// File: doc/image_streamer.md
IMAGE_STREAMER -- requirements
Module: image_streamer

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 784, meaning 32-bit pixel words per input image.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16 (power of two), meaning the pixel buffer depth in words.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port start_load, input, 1, a pulse requesting a weight-load sequence.
REQ-006 SHALL have port load_weight_done, input, 1, asserted by the network when all layer weights are loaded.
REQ-007 SHALL have port s_valid, input, 1, host pixel word valid.
REQ-008 SHALL have port s_data, input, 32, host pixel word.
REQ-009 SHALL have port s_ready, output, 1, the buffer can accept a word this cycle.
REQ-010 SHALL have port load, output, 1, the weight-load enable to the network.
REQ-011 SHALL have port input_valid, output, 1, d_in carries a valid pixel word.
REQ-012 SHALL have port sof, output, 1, marks the first word of a frame; qualified by input_valid.
REQ-013 SHALL have port d_in, output, 32, the pixel word to the network.
REQ-014 SHALL have port frame_done, output, 1, a one-cycle pulse coincident with the last word of a frame.
REQ-015 SHALL have port frame_cnt, output, 16, the count of frames fully emitted.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD and RUN; reset state IDLE.
REQ-017 IDLE: start_load=1 -> LOAD; otherwise stay in IDLE.
REQ-018 LOAD: load=1; load_weight_done=1 -> RUN with load=0 from the next cycle.
REQ-019 RUN: start_load=1 with word_idx==0 and no word emitted that cycle -> LOAD; otherwise start_load is ignored (no mid-frame reload).
REQ-020 load SHALL be registered and equal to 1 exactly while the state is LOAD.
REQ-021 FIFO: a word is written when s_valid && s_ready; s_ready = (count < FIFO_DEPTH), derived from the registered count.
REQ-022 Host words SHALL be buffered in all states; the FIFO pops only in RUN.
REQ-023 Pop rule: in RUN, one word per cycle whenever the FIFO is non-empty; input_valid, d_in and sof are registered from the popped word.
REQ-024 Latency: a word written into an empty FIFO at edge k in RUN appears with input_valid=1 after edge k+1 (cycle k+1).
REQ-025 A simultaneous push and pop SHALL leave count unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-026 word_idx SHALL run 0..FRAME_WORDS-1 and advance on each emitted word; sof=1 when an emitted word has word_idx==0.
REQ-027 When the emitted word has word_idx==FRAME_WORDS-1: frame_done=1 in that cycle, word_idx returns to 0, and frame_cnt increments (wraps 65535->0).
REQ-028 When input_valid=0, d_in SHALL hold its last value, and sof and frame_done SHALL be 0.
REQ-029 FIFO empty mid-frame: input_valid deasserts (gap); word_idx holds; the frame resumes without a new sof.
REQ-030 load_weight_done asserted outside LOAD SHALL be ignored.

Reset
REQ-031 While rst=0, asynchronously: state=IDLE, and load, input_valid, sof, frame_done, d_in, frame_cnt, word_idx, the FIFO pointers and count all = 0; s_ready=1 after release.
REQ-032 Reset mid-frame or mid-load SHALL discard buffered words and the partial frame; after release the next emitted word carries sof=1.

Verification
REQ-033 Reset, pulse start_load, raise load_weight_done 5 cycles later -> load high for exactly 6 cycles, state RUN.
REQ-034 FRAME_WORDS=4, push 0x11..0x14 back-to-back in RUN -> d_in 0x11..0x14 on consecutive cycles; sof only with 0x11; frame_done with 0x14; frame_cnt=1.
REQ-035 Push 20 words while in IDLE -> s_ready falls after 16 accepts; after load completes, 16 words stream in order, then the remaining 4.
REQ-036 Stall host after 2 of 4 words for 3 cycles -> input_valid low 3 cycles; words 3-4 follow with no sof; one frame_done.
REQ-037 Pulse start_load mid-frame -> ignored; pulse at frame boundary -> LOAD entered, streaming paused until load_weight_done.
REQ-038 Assert rst during word 2 of a frame -> all outputs 0 immediately; the next frame's first word has sof=1 and frame_cnt restarts from 0.
